// File: rtl/syn_gpu_pkg.sv
// rtl/syn_gpu_pkg.sv - shared GPU types, canvas geometry and pixel gateway state encoding
package syn_gpu_pkg;

    localparam int P_X_W        = 10;
    localparam int P_Y_W        = 9;
    localparam int P_CANVAS_W   = 640;
    localparam int P_CANVAS_H   = 480;
    localparam int P_MEM_ADDR_W = 19;

    localparam int P_MISC_NORM_W = 8;
    localparam int P_MISC_DIST_W = 12;

    typedef struct packed {
        logic [5:0] hue;
        logic [4:0] sat;
        logic [4:0] inten;
    } pxl_hsi_t;

    localparam int P_PXL_W = $bits(pxl_hsi_t);

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_WR_ISSUE = 2'd1,
        GW_RD_ISSUE = 2'd2,
        GW_RD_WAIT  = 2'd3
    } gw_state_e;

endpackage

// File: rtl/syn_pxl_gw_addr_calc.sv
// rtl/syn_pxl_gw_addr_calc.sv - canvas (x,y) to linear frame-buffer word address plus in-range flag
module syn_pxl_gw_addr_calc
    import syn_gpu_pkg::*;
(
    input  logic [P_X_W-1:0]        posx_i,
    input  logic [P_Y_W-1:0]        posy_i,
    output logic [P_MEM_ADDR_W-1:0] addr_o,
    output logic                    in_range_o
);

    localparam logic [P_X_W-1:0] CANVAS_W_X = P_X_W'(P_CANVAS_W);
    localparam logic [P_Y_W-1:0] CANVAS_H_Y = P_Y_W'(P_CANVAS_H);

    logic [P_MEM_ADDR_W-1:0] x_ext;
    logic [P_MEM_ADDR_W-1:0] y_ext;

    assign x_ext = P_MEM_ADDR_W'(posx_i);
    assign y_ext = P_MEM_ADDR_W'(posy_i);

    // y*640 as y*512 + y*128; wraps modulo 2^P_MEM_ADDR_W for out-of-canvas input
    assign addr_o = (y_ext << 9) + (y_ext << 7) + x_ext;

    assign in_range_o = (posx_i < CANVAS_W_X) && (posy_i < CANVAS_H_Y);

endmodule

// File: rtl/syn_gpu_pxl_gw.sv
// rtl/syn_gpu_pxl_gw.sv - pixel gateway core->frame-buffer; SYN_PXL_GW_RANGE_CHK_EN drops off-canvas requests
module syn_gpu_pxl_gw
    import syn_gpu_pkg::*;
(
    input  logic                     clk_ir,
    input  logic                     rst_sync_l,
    input  logic                     pxl_wr_valid,
    input  logic                     pxl_rd_valid,
    input  logic [P_X_W-1:0]         posx,
    input  logic [P_Y_W-1:0]         posy,
    input  logic [P_PXL_W-1:0]       pxl,
    input  logic [P_MISC_NORM_W-1:0] misc_info_norm,
    input  logic [P_MISC_DIST_W-1:0] misc_info_dist,
    output logic                     ready,
    output logic [P_PXL_W-1:0]       rd_pxl,
    output logic                     rd_pxl_valid,
    output logic                     mem_wr_en,
    output logic                     mem_rd_en,
    output logic [P_MEM_ADDR_W-1:0]  mem_addr,
    output logic [P_PXL_W-1:0]       mem_wdata,
    input  logic                     mem_wait,
    input  logic [P_PXL_W-1:0]       mem_rdata,
    input  logic                     mem_rd_valid
);

    gw_state_e state_q, state_d;
    gw_state_e accept_next;

    logic                    accept;
    logic                    req_drop;
    logic [P_MEM_ADDR_W-1:0] calc_addr;
    logic                    calc_in_range;

    logic [P_MEM_ADDR_W-1:0] addr_q;
    logic [P_PXL_W-1:0]      wdata_q;
    logic [P_PXL_W-1:0]      rd_pxl_q;
    logic                    rd_pxl_valid_q;

    syn_pxl_gw_addr_calc u_addr_calc (
        .posx_i     (posx),
        .posy_i     (posy),
        .addr_o     (calc_addr),
        .in_range_o (calc_in_range)
    );

    logic unused_sigs;
`ifdef SYN_PXL_GW_RANGE_CHK_EN
    assign req_drop    = ~calc_in_range;
    assign unused_sigs = ^{misc_info_norm, misc_info_dist};
`else
    assign req_drop    = 1'b0;
    assign unused_sigs = ^{misc_info_norm, misc_info_dist, calc_in_range};
`endif

    // A write wins when both valids are high
    assign accept = (pxl_wr_valid | pxl_rd_valid) & ready;

    always_comb begin
        accept_next = GW_IDLE;
        if (!req_drop) begin
            accept_next = pxl_wr_valid ? GW_WR_ISSUE : GW_RD_ISSUE;
        end
    end

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q <= GW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GW_IDLE, GW_WR_ISSUE: begin
                if (ready) begin
                    state_d = accept ? accept_next : GW_IDLE;
                end
            end
            GW_RD_ISSUE: begin
                if (!mem_wait) begin
                    state_d = GW_RD_WAIT;
                end
            end
            GW_RD_WAIT: begin
                if (mem_rd_valid) begin
                    state_d = GW_IDLE;
                end
            end
            default: state_d = GW_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == GW_IDLE) | ((state_q == GW_WR_ISSUE) & ~mem_wait);
        mem_wr_en = (state_q == GW_WR_ISSUE);
        mem_rd_en = (state_q == GW_RD_ISSUE);
    end

    // Request slot only reloads on accept, so address/data hold for the whole strobe
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q <= calc_addr;
            if (pxl_wr_valid) begin
                wdata_q <= pxl;
            end
        end
    end

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            rd_pxl_q       <= '0;
            rd_pxl_valid_q <= 1'b0;
        end else begin
            rd_pxl_valid_q <= 1'b0;
            if ((state_q == GW_RD_WAIT) && mem_rd_valid) begin
                rd_pxl_q       <= mem_rdata;
                rd_pxl_valid_q <= 1'b1;
            end else if (accept && !pxl_wr_valid && req_drop) begin
                rd_pxl_q       <= '0;
                rd_pxl_valid_q <= 1'b1;
            end
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign rd_pxl       = rd_pxl_q;
    assign rd_pxl_valid = rd_pxl_valid_q;

endmodule
